load_store_unit: RTL and testbench

- MEM-stage front end placed directly upstream of the word-addressed data memory. That memory has a combinational read and writes on the negedge of clk.
- Turns pipeline load/store requests (byte, half, word; signed or unsigned loads) into word-only memory accesses.
- Sub-word stores use a two-cycle read-modify-write. The unit returns extended load data to the MEM/WB register.
- Stalls the pipeline during read-modify-write and flags misaligned accesses.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/load_store_unit_if.sv | 31 +++
 rtl/lsu_align.sv | 46 ++++
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } lsu_state_e;

    // Size 2'b11 is handled as a word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            default: bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory signals of the load/store unit.
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              stall;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              fault;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output stall, resp_valid, resp_rdata, fault, mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  stall, resp_valid, resp_rdata, fault, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling: load extraction/extension and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_lane,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old,
    input  logic [31:0] st_new,
    input  logic [1:0]  st_lane,
    input  logic [1:0]  st_size,
    output logic [31:0] st_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
        ld_half = ld_word[{ld_lane[1], 4'b0000} +: 16];
        ld_data = ld_word;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        st_word = st_new;
        case (st_size)
            SZ_BYTE: begin
                st_word = st_old;
                st_word[{st_lane, 3'b000} +: 8] = st_new[7:0];
            end
            SZ_HALF: begin
                st_word = st_old;
                st_word[{st_lane[1], 4'b0000} +: 16] = st_new[15:0];
            end
            default: st_word = st_new;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end: word-only memory access, sub-word stores via read-modify-write.
// Misalignment faults are enabled by defining LSU_FAULT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   bus
);

    lsu_state_e        state, state_nx;
    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_lane;
    logic [1:0]        lat_size;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] lat_old;
    logic              req_mis;
    logic              req_subword;
    logic [ADDR_W-1:0] req_word_addr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_word;

`ifdef LSU_FAULT_EN
    assign req_mis = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign req_mis = 1'b0;
`endif

    assign req_subword   = (bus.req_size == SZ_BYTE) || (bus.req_size == SZ_HALF);
    assign req_word_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};

    lsu_align u_align (
        .ld_word     (bus.mem_rdata),
        .ld_lane     (bus.req_addr[1:0]),
        .ld_size     (bus.req_size),
        .ld_unsigned (bus.req_unsigned),
        .ld_data     (ld_data),
        .st_old      (lat_old),
        .st_new      (lat_wdata),
        .st_lane     (lat_lane),
        .st_size     (lat_size),
        .st_word     (st_word)
    );

    always_comb begin
        state_nx      = state;
        bus.stall     = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = req_word_addr;
        bus.mem_wdata = bus.req_wdata;
        unique case (state)
            ST_IDLE: begin
                if (bus.req_valid && !req_mis) begin
                    if (!bus.req_write) begin
                        bus.mem_read = 1'b1;
                    end else if (!req_subword) begin
                        bus.mem_write = 1'b1;
                    end else begin
                        bus.mem_read = 1'b1;
                        bus.stall    = 1'b1;
                        state_nx     = ST_RMW;
                    end
                end
            end
            ST_RMW: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = lat_addr;
                bus.mem_wdata = st_word;
                state_nx      = ST_IDLE;
            end
        endcase
        // Reset must also kill a pending RMW write, not just the state.
        if (reset) begin
            bus.stall     = 1'b0;
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            lat_addr       <= '0;
            lat_lane       <= '0;
            lat_size       <= '0;
            lat_wdata      <= '0;
            lat_old        <= '0;
        end else begin
            state          <= state_nx;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (req_mis) begin
                            bus.resp_valid <= 1'b1;
                        end else if (!bus.req_write) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= ld_data;
                        end else if (!req_subword) begin
                            bus.resp_valid <= 1'b1;
                        end else begin
                            lat_addr  <= req_word_addr;
                            lat_lane  <= bus.req_addr[1:0];
                            lat_size  <= bus.req_size;
                            lat_wdata <= bus.req_wdata;
                            lat_old   <= bus.mem_rdata;
                        end
                    end
                end
                ST_RMW: bus.resp_valid <= 1'b1;
            endcase
        end
    end

`ifdef LSU_FAULT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.fault <= 1'b0;
        end else begin
            bus.fault <= (state == ST_IDLE) && bus.req_valid && req_mis;
        end
    end
`else
    assign bus.fault = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word memory model, directed cases, randomized traffic.
module tb_load_store_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory seen by the DUT: combinational read, negedge write.
    logic [31:0] mem [0:63];
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
    always @(negedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    // Reference model state.
    logic [31:0] ref_mem [0:63];
    logic        m_rmw;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_size;
    logic        exp_rv;
    logic        exp_f;
    logic [31:0] exp_rd;

    function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] a);
        logic [31:0] v;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            v = (w >> sh) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = 16 * int'(a[1]);
            v = (w >> sh) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'h0000_00FF << sh;
        end else begin
            sh = 16 * int'(a[1]);
            mask = 32'h0000_FFFF << sh;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    function automatic logic f_mis(input logic [1:0] sz, input logic [31:0] a);
        logic en;
        logic bad;
`ifdef LSU_FAULT_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        if (sz == 2'b00)      bad = 1'b0;
        else if (sz == 2'b01) bad = (a % 2) != 0;
        else                  bad = (a % 4) != 0;
        return en && bad;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: advances at each rising edge using the request rules.
    always @(posedge clk) begin
        if (reset) begin
            m_rmw  = 1'b0;
            exp_rv = 1'b0;
            exp_f  = 1'b0;
            exp_rd = '0;
        end else if (m_rmw) begin
            ref_mem[m_addr[7:2]] = f_merge(ref_mem[m_addr[7:2]], m_wdata, m_size, m_addr);
            m_rmw  = 1'b0;
            exp_rv = 1'b1;
            exp_f  = 1'b0;
            exp_rd = '0;
        end else if (bus.req_valid) begin
            exp_rv = 1'b1;
            exp_f  = 1'b0;
            exp_rd = '0;
            if (f_mis(bus.req_size, bus.req_addr)) begin
                exp_f = 1'b1;
            end else if (!bus.req_write) begin
                exp_rd = f_load(ref_mem[bus.req_addr[7:2]], bus.req_size, bus.req_unsigned, bus.req_addr);
            end else if (bus.req_size[1]) begin
                ref_mem[bus.req_addr[7:2]] = bus.req_wdata;
            end else begin
                m_rmw   = 1'b1;
                m_addr  = bus.req_addr;
                m_wdata = bus.req_wdata;
                m_size  = bus.req_size;
                exp_rv  = 1'b0;
            end
        end else begin
            exp_rv = 1'b0;
            exp_f  = 1'b0;
            exp_rd = '0;
        end
    end

    // Compare process: every cycle, mid-way between edges.
    always begin
        logic        e_st, e_rd, e_wr, c_addr, c_wd;
        logic [31:0] e_addr, e_wd;
        @(negedge clk);
        #3;
        e_st = 0; e_rd = 0; e_wr = 0; c_addr = 0; c_wd = 0;
        e_addr = '0; e_wd = '0;
        if (reset) begin
            e_st = 0;
        end else if (m_rmw) begin
            e_wr = 1; c_addr = 1; c_wd = 1;
            e_addr = {m_addr[31:2], 2'b00};
            e_wd = f_merge(ref_mem[m_addr[7:2]], m_wdata, m_size, m_addr);
        end else if (bus.req_valid && !f_mis(bus.req_size, bus.req_addr)) begin
            c_addr = 1;
            e_addr = {bus.req_addr[31:2], 2'b00};
            if (!bus.req_write) begin
                e_rd = 1;
            end else if (bus.req_size[1]) begin
                e_wr = 1; c_wd = 1; e_wd = bus.req_wdata;
            end else begin
                e_rd = 1; e_st = 1;
            end
        end
        chk("stall", 32'(bus.stall), 32'(e_st));
        chk("mem_read", 32'(bus.mem_read), 32'(e_rd));
        chk("mem_write", 32'(bus.mem_write), 32'(e_wr));
        if (c_addr) chk("mem_addr", bus.mem_addr, e_addr);
        if (c_wd) chk("mem_wdata", bus.mem_wdata, e_wd);
        chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
        chk("fault", 32'(bus.fault), 32'(exp_f));
        if (exp_rv) chk("resp_rdata", bus.resp_rdata, exp_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #3;
    endtask

    task automatic set_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
    endtask

    // Present a request and hold it until it retires (bounded).
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        logic st;
        set_req(w, sz, u, a, d);
        for (int g = 0; g < 8; g++) begin
            samp();
            st = bus.stall;
            tick();
            if (!st) break;
            if (g == 7) begin
                n_checks++;
                n_fail++;
                $display("FAIL stall_bound: stall held past 8 cycles at %0t", $time);
            end
        end
    endtask

    task automatic idle_samp();
        bus.req_valid = 1'b0;
        samp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4]      = 32'h8899AABB;
        ref_mem[4]  = 32'h8899AABB;
        mem[12]     = 32'h0BADF00D;
        ref_mem[12] = 32'h0BADF00D;

        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) tick();
        samp();
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        tick();
        reset = 1'b0;

        // Signed byte load at 0x11.
        set_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        samp();
        chk("lb_mem_read", 32'(bus.mem_read), 32'd1);
        chk("lb_mem_addr", bus.mem_addr, 32'h10);
        tick();
        idle_samp();
        chk("lb_valid", 32'(bus.resp_valid), 32'd1);
        chk("lb_rdata", bus.resp_rdata, 32'hFFFFFFAA);
        tick();

        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        idle_samp();
        chk("lhu_rdata", bus.resp_rdata, 32'h00008899);
        tick();
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        idle_samp();
        chk("lw_rdata", bus.resp_rdata, 32'h8899AABB);
        tick();

        // Byte store 0xCC at 0x13: stall cycle, merge cycle, response.
        set_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000CC);
        samp();
        chk("sb_c1_stall", 32'(bus.stall), 32'd1);
        chk("sb_c1_read", 32'(bus.mem_read), 32'd1);
        tick();
        samp();
        chk("sb_c2_write", 32'(bus.mem_write), 32'd1);
        chk("sb_c2_wdata", bus.mem_wdata, 32'hCC99AABB);
        chk("sb_c2_stall", 32'(bus.stall), 32'd0);
        tick();
        idle_samp();
        chk("sb_c3_valid", 32'(bus.resp_valid), 32'd1);
        chk("sb_c3_rdata", bus.resp_rdata, 32'd0);
        tick();

        // Word store then word load back-to-back.
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        idle_samp();
        chk("sw_lw_rdata", bus.resp_rdata, 32'h12345678);
        tick();

        // Half load at odd address 0x21.
        do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
        idle_samp();
`ifdef LSU_FAULT_EN
        chk("mis_fault", 32'(bus.fault), 32'd1);
        chk("mis_rdata", bus.resp_rdata, 32'd0);
`else
        chk("mis_as_aligned", bus.resp_rdata, 32'h00005678);
`endif
        tick();

        // Reset during the RMW cycle of a half store to 0x30.
        set_req(1'b1, 2'b01, 1'b0, 32'h30, 32'h0000BEEF);
        samp();
        tick();
        reset = 1'b1;
        samp();
        chk("rst_rmw_write", 32'(bus.mem_write), 32'd0);
        tick();
        reset = 1'b0;
        idle_samp();
        chk("rst_rmw_valid", 32'(bus.resp_valid), 32'd0);
        tick();
        do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        idle_samp();
        chk("rst_rmw_word", bus.resp_rdata, 32'h0BADF00D);
        tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            logic [31:0] a;
            logic [1:0]  sz;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                bus.req_valid = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end else if (r == 1) begin
                bus.req_valid = 1'b0;
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                sz = 2'($urandom_range(0, 3));
                a  = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) begin
                    if (sz == 2'b01) a = a & 32'hFFFF_FFFE;
                    else if (sz[1]) a = a & 32'hFFFF_FFFC;
                end
                do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            end
        end

        bus.req_valid = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
